// File: rtl/comp_serial_mag.sv
// Multi-cycle magnitude comparator. It scans two operands MSB-first, DIGIT bits per cycle,
// and reports gt/lt/eq plus the index of the highest differing bit through a valid/ready handshake.
module comp_serial_mag #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [WIDTH-1:0]         x,
  input  logic [WIDTH-1:0]         y,
  input  logic                     signed_mode,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     mayorQue,
  output logic                     menorQue,
  output logic                     igual,
  output logic [$clog2(WIDTH)-1:0] diff_idx
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(WIDTH);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_param
      $error("comp_serial_mag: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // start_ready is high only in IDLE, and res_valid is high only in DONE.
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] xs, ys;
  logic [CW-1:0]    cnt;
  logic             found, gt_q;
  logic [IW-1:0]    idx_q;

  logic [DIGIT-1:0] xd, yd, dd;
  logic             first_hit;
  logic [IW-1:0]    hit_idx;
  logic             accept, release_res;

  assign xd          = xs[WIDTH-1 -: DIGIT];
  assign yd          = ys[WIDTH-1 -: DIGIT];
  assign dd          = xd ^ yd;
  assign first_hit   = (state == SCAN) && (|dd) && !found;
  assign accept      = start_valid && start_ready;
  assign release_res = (state == DONE) && res_ready;

  // The digit held in the top of the shift registers sits at absolute bits cnt*DIGIT and up.
  always_comb begin
    int hit_pos;
    hit_pos = 0;
    for (int j = 0; j < DIGIT; j++) begin
      if (dd[j]) hit_pos = j;
    end
    hit_idx = IW'(int'(cnt) * DIGIT + hit_pos);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = SCAN;
      SCAN: begin
        if ((EARLY_EXIT != 0) && first_hit) state_nx = DONE;
        else if (cnt == '0)                 state_nx = DONE;
      end
      DONE: if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Signed mode flips both MSBs so that an unsigned scan orders two's-complement values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs    <= '0;
      ys    <= '0;
      cnt   <= '0;
      found <= 1'b0;
      gt_q  <= 1'b0;
      idx_q <= '0;
    end else if (accept) begin
      xs    <= {x[WIDTH-1] ^ signed_mode, x[WIDTH-2:0]};
      ys    <= {y[WIDTH-1] ^ signed_mode, y[WIDTH-2:0]};
      cnt   <= CW'(N - 1);
      found <= 1'b0;
      gt_q  <= 1'b0;
      idx_q <= '0;
    end else if (state == SCAN) begin
      xs  <= xs << DIGIT;
      ys  <= ys << DIGIT;
      cnt <= cnt - 1'b1;
      if (first_hit) begin
        found <= 1'b1;
        gt_q  <= (xd > yd);
        idx_q <= hit_idx;
      end
    end else if (release_res) begin
      xs    <= '0;
      ys    <= '0;
      found <= 1'b0;
      gt_q  <= 1'b0;
      idx_q <= '0;
    end
  end

  // Result outputs are gated by DONE, so the flags are all 0 whenever res_valid is low.
  always_comb begin
    start_ready = (state == IDLE);
    res_valid   = (state == DONE);
    mayorQue    = res_valid && found && gt_q;
    menorQue    = res_valid && found && !gt_q;
    igual       = res_valid && !found;
    diff_idx    = res_valid ? idx_q : '0;
  end

endmodule
